// File: rtl/quick_cpu_pkg.sv
// Shared definitions for the quick_cpu program loader: memory geometry and loader state encoding.
package quick_cpu_pkg;

    localparam int IMEM_ADDR_W = 5;
    localparam int INSTR_W     = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        WRITE = 3'd3,
        RUN   = 3'd4
    } loader_state_e;

endpackage

// File: rtl/quick_cpu_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall pulses derived from the synchronised level.
module quick_cpu_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next state of the synchroniser chain and the edge-history flop
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchroniser and history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/quick_cpu_loader.sv
// Program loader: packs strobed bytes little-endian into instruction words and holds the core in reset while loading.
// Optional feature: define QUICK_CPU_LOADER_CHECKSUM_EN for a mod-256 byte-sum on the checksum port.
module quick_cpu_loader
    import quick_cpu_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_pin,
    input  logic              strobe_pin,
    input  logic [7:0]        byte_pin,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic              odd_err,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    logic load_level_s, load_rise_s, load_fall_s;
    logic strobe_level_s, strobe_rise_s, strobe_fall_s;

    quick_cpu_sync_edge u_load_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (load_pin),
        .level    (load_level_s),
        .rise     (load_rise_s),
        .fall     (load_fall_s)
    );

    quick_cpu_sync_edge u_strobe_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (strobe_pin),
        .level    (strobe_level_s),
        .rise     (strobe_rise_s),
        .fall     (strobe_fall_s)
    );

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [7:0]        lo_q, lo_d;
    logic              overflow_q, overflow_d;
    logic              odd_err_q, odd_err_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              cpu_run_q, cpu_run_d;
    logic              full_s;
    logic              session_clear_s;
    logic              byte_capture_s;

    assign full_s = (word_count_q == FULL_COUNT);

    // Loader FSM: next state, capture registers and the registered memory-write port
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        word_count_d    = word_count_q;
        lo_d            = lo_q;
        overflow_d      = overflow_q;
        odd_err_d       = odd_err_q;
        imem_we_d       = 1'b0;
        imem_addr_d     = imem_addr_q;
        imem_wdata_d    = imem_wdata_q;
        session_clear_s = 1'b0;
        byte_capture_s  = 1'b0;

        case (state_q)
            IDLE, RUN: begin
                if (load_rise_s) begin
                    session_clear_s = 1'b1;
                    addr_d          = {ADDR_W{1'b0}};
                    word_count_d    = {(ADDR_W+1){1'b0}};
                    overflow_d      = 1'b0;
                    odd_err_d       = 1'b0;
                    state_d         = LO;
                end else begin
                    state_d = state_q;
                end
            end
            LO: begin
                if (!load_level_s) begin
                    state_d = RUN;
                end else if (strobe_rise_s) begin
                    if (full_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        lo_d           = byte_pin;
                        byte_capture_s = 1'b1;
                        state_d        = HI;
                    end
                end else begin
                    state_d = LO;
                end
            end
            HI: begin
                if (!load_level_s) begin
                    odd_err_d = 1'b1;
                    state_d   = RUN;
                end else if (strobe_rise_s) begin
                    if (full_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        // Write port is loaded here so it is valid together with imem_we in WRITE
                        imem_we_d      = 1'b1;
                        imem_addr_d    = addr_q;
                        imem_wdata_d   = {byte_pin, lo_q};
                        byte_capture_s = 1'b1;
                        state_d        = WRITE;
                    end
                end else begin
                    state_d = HI;
                end
            end
            WRITE: begin
                addr_d       = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
                state_d      = LO;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_run_d = (state_d == RUN);
    end

    // Loader state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            word_count_q <= {(ADDR_W+1){1'b0}};
            lo_q         <= 8'h00;
            overflow_q   <= 1'b0;
            odd_err_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= {DATA_W{1'b0}};
            cpu_run_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            lo_q         <= lo_d;
            overflow_q   <= overflow_d;
            odd_err_q    <= odd_err_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_run_q    <= cpu_run_d;
        end
    end

`ifdef QUICK_CPU_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    // Running byte sum over captured bytes; overflow-dropped bytes never assert byte_capture_s
    always_comb begin
        if (session_clear_s) begin
            checksum_d = 8'h00;
        end else if (byte_capture_s) begin
            checksum_d = checksum_q + byte_pin;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= 8'h00;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_run    = cpu_run_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;
    assign odd_err    = odd_err_q;

endmodule

// File: tb/tb_quick_cpu_loader.sv
// Self-checking bench for quick_cpu_loader: directed and random load sessions against a byte-list reference model.
module tb_quick_cpu_loader;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_pin = 1'b0;
    logic          strobe_pin = 1'b0;
    logic [7:0]    byte_pin = 8'h00;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_run;
    logic [AW:0]   word_count;
    logic          overflow;
    logic          odd_err;
    logic [7:0]    checksum;

    int checks = 0;
    int errors = 0;

    logic [7:0] sess_bytes[$];
    int         log_addr[$];
    int         log_data[$];
    int         log_start;

    quick_cpu_loader #(.ADDR_W(AW), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_pin   (load_pin),
        .strobe_pin (strobe_pin),
        .byte_pin   (byte_pin),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .word_count (word_count),
        .overflow   (overflow),
        .odd_err    (odd_err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Record every memory write seen on the port, one entry per high cycle of imem_we
    always @(negedge clk) begin
        if (imem_we) begin
            log_addr.push_back(int'(imem_addr));
            log_data.push_back(int'(imem_wdata));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic new_model();
        sess_bytes.delete();
        log_start = log_addr.size();
    endtask

    task automatic send(input logic [7:0] b);
        byte_pin = b;
        sess_bytes.push_back(b);
        cyc(1);
        strobe_pin = 1'b1;
        cyc(4);
        strobe_pin = 1'b0;
        cyc(4);
    endtask

    task automatic begin_session();
        new_model();
        load_pin = 1'b1;
        cyc(3);
        check("start_cpu_run", 32'(cpu_run), 32'd0);
        check("start_word_count", 32'(word_count), 32'd0);
        cyc(2);
    endtask

    // Expected results follow directly from the list of bytes sent this session
    task automatic end_and_check(input string name);
        int n, captured, words, sum, nlog;
        logic exp_ovf, exp_odd;
        n        = sess_bytes.size();
        captured = (n > 2 * DEPTH) ? 2 * DEPTH : n;
        words    = captured / 2;
        exp_ovf  = (n > 2 * DEPTH);
        exp_odd  = (captured % 2) == 1;
        sum      = 0;
        for (int i = 0; i < captured; i++) sum += int'(sess_bytes[i]);
        load_pin = 1'b0;
        cyc(2);
        check({name, "_run_latency_lo"}, 32'(cpu_run), 32'd0);
        cyc(1);
        check({name, "_run_latency_hi"}, 32'(cpu_run), 32'd1);
        cyc(3);
        check({name, "_word_count"}, 32'(word_count), 32'(words));
        check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check({name, "_odd_err"}, 32'(odd_err), 32'(exp_odd));
`ifdef QUICK_CPU_LOADER_CHECKSUM_EN
        check({name, "_checksum"}, 32'(checksum), 32'(sum % 256));
`else
        check({name, "_checksum"}, 32'(checksum), 32'd0);
`endif
        nlog = log_addr.size() - log_start;
        check({name, "_num_writes"}, 32'(nlog), 32'(words));
        for (int i = 0; i < words && i < nlog; i++) begin
            check({name, "_waddr"}, 32'(log_addr[log_start + i]), 32'(i));
            check({name, "_wdata"}, 32'(log_data[log_start + i]),
                  32'(int'(sess_bytes[2 * i + 1]) * 256 + int'(sess_bytes[2 * i])));
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_imem_we"}, 32'(imem_we), 32'd0);
        check({name, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({name, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
        check({name, "_cpu_run"}, 32'(cpu_run), 32'd0);
        check({name, "_word_count"}, 32'(word_count), 32'd0);
        check({name, "_overflow"}, 32'(overflow), 32'd0);
        check({name, "_odd_err"}, 32'(odd_err), 32'd0);
        check({name, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        int n;
        cyc(3);
        check_reset_values("reset");
        rst = 1'b0;
        cyc(3);
        check("idle_cpu_run", 32'(cpu_run), 32'd0);

        // Two full words
        begin_session();
        send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        end_and_check("four_bytes");

        // Unpaired low byte left at the end; reload from RUN
        begin_session();
        send(8'hAA); send(8'hBB); send(8'hCC);
        end_and_check("three_bytes");

        // Checksum wrap
        begin_session();
        send(8'hFF); send(8'h01); send(8'h10);
        end_and_check("checksum");

        // Fill memory and keep strobing
        begin_session();
        for (int i = 0; i < 2 * DEPTH + 3; i++) send(8'($urandom_range(0, 255)));
        end_and_check("overflow");

        // Reset while waiting for a high byte
        begin_session();
        send(8'h5A);
        rst = 1'b1;
        cyc(1);
        check_reset_values("mid_hi_reset");
        new_model();
        rst = 1'b0;
        cyc(6);
        send(8'hC3); send(8'h3C);
        end_and_check("after_reset");

        // Empty session
        begin_session();
        end_and_check("empty");

        // Random sessions, each a reload from RUN
        for (int s = 0; s < 6; s++) begin
            begin_session();
            n = $urandom_range(1, 2 * DEPTH + 2);
            for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)));
            end_and_check("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
